// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM peripheral on the system bus.
//
// Each channel has a free-running counter with double-buffered duty and
// period registers. Shadow registers are written over the bus; active
// registers reload from the shadows at every period boundary, on a global
// SYNC write, and continuously while the channel is disabled. Because of
// this, a duty or period change never produces a runt pulse.
//
// Ports:
//   clk_i, rst_ni     system clock, asynchronous active-low reset
//   device_req_i      bus request, one transaction per asserted cycle
//   device_addr_i     byte address, bits [11:2] decoded
//   device_we_i       1 = write, 0 = read
//   device_be_i       byte enables for writes
//   device_wdata_i    write data
//   device_rvalid_o   response valid, one cycle after each request
//   device_rdata_o    read data (0 for unmapped offsets and SYNC)
//   device_err_o      unmapped offset, qualified by device_rvalid_o
//   pwm_o             registered PWM outputs
//
// Register map (byte offset):
//   0x000 + 8*i  DUTY[i] shadow      0x004 + 8*i  PERIOD[i] shadow
//   0x800        ENABLE              0x804        SYNC (write-only)
module pwm_bank #(
  parameter int unsigned NumChannels = 12,
  parameter int unsigned CtrWidth    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   device_req_i,
  input  logic [31:0]            device_addr_i,
  input  logic                   device_we_i,
  input  logic [3:0]             device_be_i,
  input  logic [31:0]            device_wdata_i,
  output logic                   device_rvalid_o,
  output logic [31:0]            device_rdata_o,
  output logic                   device_err_o,
  output logic [NumChannels-1:0] pwm_o
);

  // ENABLE is a single 32-bit word, so only the first 32 channels can be
  // enabled when NumChannels exceeds 32.
  localparam int unsigned EnWidth = (NumChannels < 32) ? NumChannels : 32;

  typedef enum logic [1:0] {
    RegNone,
    RegChan,
    RegEnable,
    RegSync
  } reg_sel_e;

  logic [9:0]  word;
  logic [31:0] ch_idx;
  reg_sel_e    reg_sel;
  logic        wr_en;
  logic        chan_wr;
  logic        sync_pulse;
  logic [31:0] wmask;

  assign word   = device_addr_i[11:2];
  assign ch_idx = {24'b0, word[8:1]};

  always_comb begin
    reg_sel = RegNone;
    if (!word[9]) begin
      if (ch_idx < NumChannels) reg_sel = RegChan;
    end else if (word == 10'h200) begin
      reg_sel = RegEnable;
    end else if (word == 10'h201) begin
      reg_sel = RegSync;
    end
  end

  assign wmask = {{8{device_be_i[3]}}, {8{device_be_i[2]}},
                  {8{device_be_i[1]}}, {8{device_be_i[0]}}};

  assign wr_en      = device_req_i && device_we_i;
  assign chan_wr    = wr_en && (reg_sel == RegChan);
  assign sync_pulse = wr_en && (reg_sel == RegSync) && (|device_be_i) && device_wdata_i[0];

  // Enable register; en_d is its next value so a channel being disabled
  // clears its counter on the same edge that clears the enable bit.
  logic [NumChannels-1:0] en_q;
  logic [NumChannels-1:0] en_d;

  always_comb begin
    en_d = en_q;
    if (wr_en && (reg_sel == RegEnable)) begin
      en_d[EnWidth-1:0] = (en_q[EnWidth-1:0] & ~wmask[EnWidth-1:0]) |
                          (device_wdata_i[EnWidth-1:0] & wmask[EnWidth-1:0]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q <= '0;
    end else begin
      en_q <= en_d;
    end
  end

  logic [NumChannels-1:0][CtrWidth-1:0] duty_sh;
  logic [NumChannels-1:0][CtrWidth-1:0] per_sh;

  for (genvar i = 0; i < NumChannels; i++) begin : g_ch
    logic [CtrWidth-1:0] duty_sh_q;
    logic [CtrWidth-1:0] per_sh_q;
    logic [CtrWidth-1:0] duty_act_q;
    logic [CtrWidth-1:0] per_act_q;
    logic [CtrWidth-1:0] cnt_q;
    logic                pwm_q;
    logic                duty_wr;
    logic                per_wr;
    logic                run;
    logic                reload;

    assign duty_wr = chan_wr && (ch_idx == i) && !word[0];
    assign per_wr  = chan_wr && (ch_idx == i) &&  word[0];

    // Counting only while enabled both now and after this edge; any other
    // case (disabled, just enabled, just disabled) holds the counter at 0
    // with the actives tracking the shadows.
    assign run    = en_q[i] && en_d[i];
    assign reload = !run || sync_pulse || (cnt_q == per_act_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        duty_sh_q <= '0;
        per_sh_q  <= '0;
      end else begin
        if (duty_wr) begin
          duty_sh_q <= (duty_sh_q & ~wmask[CtrWidth-1:0]) |
                       (device_wdata_i[CtrWidth-1:0] & wmask[CtrWidth-1:0]);
        end
        if (per_wr) begin
          per_sh_q <= (per_sh_q & ~wmask[CtrWidth-1:0]) |
                      (device_wdata_i[CtrWidth-1:0] & wmask[CtrWidth-1:0]);
        end
      end
    end

    // Actives load the pre-write shadow when a shadow write lands on a
    // boundary edge; the new value waits for the following boundary.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q      <= '0;
        duty_act_q <= '0;
        per_act_q  <= '0;
        pwm_q      <= 1'b0;
      end else begin
        if (reload) begin
          cnt_q      <= '0;
          duty_act_q <= duty_sh_q;
          per_act_q  <= per_sh_q;
        end else begin
          cnt_q <= cnt_q + CtrWidth'(1);
        end
        pwm_q <= en_q[i] && (cnt_q < duty_act_q);
      end
    end

    assign duty_sh[i] = duty_sh_q;
    assign per_sh[i]  = per_sh_q;
    assign pwm_o[i]   = pwm_q;
  end

  // Read mux
  logic [CtrWidth-1:0] chan_duty;
  logic [CtrWidth-1:0] chan_per;
  logic [31:0]         rd_word;

  always_comb begin
    chan_duty = '0;
    chan_per  = '0;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      if (ch_idx == i) begin
        chan_duty = duty_sh[i];
        chan_per  = per_sh[i];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      RegChan:   rd_word[CtrWidth-1:0] = word[0] ? chan_per : chan_duty;
      RegEnable: rd_word[EnWidth-1:0]  = en_q[EnWidth-1:0];
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      device_rvalid_o <= 1'b0;
      device_err_o    <= 1'b0;
      device_rdata_o  <= '0;
    end else begin
      device_rvalid_o <= device_req_i;
      device_err_o    <= device_req_i && (reg_sel == RegNone);
      device_rdata_o  <= (device_req_i && !device_we_i) ? rd_word : '0;
    end
  end

  // Address bits outside [11:2] and data/mask bits above the field widths
  // are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{device_addr_i[31:12], device_addr_i[1:0], wmask, device_wdata_i};

endmodule

// File: tb/tb_pwm_bank.sv
module tb_pwm_bank;
  localparam int N = 12;
  localparam int W = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          device_req_i = 1'b0;
  logic [31:0]   device_addr_i = '0;
  logic          device_we_i = 1'b0;
  logic [3:0]    device_be_i = '0;
  logic [31:0]   device_wdata_i = '0;
  logic          device_rvalid_o;
  logic [31:0]   device_rdata_o;
  logic          device_err_o;
  logic [N-1:0]  pwm_o;

  always #5 clk_i = ~clk_i;

  pwm_bank #(.NumChannels(N), .CtrWidth(W)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .device_req_i   (device_req_i),
    .device_addr_i  (device_addr_i),
    .device_we_i    (device_we_i),
    .device_be_i    (device_be_i),
    .device_wdata_i (device_wdata_i),
    .device_rvalid_o(device_rvalid_o),
    .device_rdata_o (device_rdata_o),
    .device_err_o   (device_err_o),
    .pwm_o          (pwm_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        err;
    logic        chk_data;
    logic [31:0] rdata;
  } rsp_t;
  rsp_t exp_q[$];

  // Reference model: integer shadows/actives and a phase within the period.
  int           m_duty[N], m_per[N], m_dact[N], m_pact[N], m_phase[N];
  bit           m_en[N];
  logic [N-1:0] m_pwm = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int merge(input int old, input logic [31:0] wd, input logic [3:0] be, input int width);
    int r;
    r = old;
    for (int b = 0; b < width; b++) if (be[b/8]) r[b] = wd[b];
    return r;
  endfunction

  function automatic rsp_t exp_rsp(input logic we, input logic [31:0] addr);
    rsp_t r;
    int   word, ch;
    r.err = 1'b0; r.chk_data = !we; r.rdata = '0;
    word = int'(addr[11:2]);
    if (word < 'h200) begin
      ch = word / 2;
      if (ch < N) r.rdata = (word % 2 == 1) ? 32'(m_per[ch]) : 32'(m_duty[ch]);
      else begin r.err = 1'b1; r.chk_data = 1'b1; end
    end else if (word == 'h200) begin
      for (int i = 0; i < N && i < 32; i++) r.rdata[i] = m_en[i];
    end else if (word != 'h201) begin
      r.err = 1'b1; r.chk_data = 1'b1;
    end
    if (we) r.rdata = '0;
    return r;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        m_duty[i] = 0; m_per[i] = 0; m_dact[i] = 0; m_pact[i] = 0; m_phase[i] = 0; m_en[i] = 0;
      end
      m_pwm = '0;
      exp_q.delete();
    end else begin
      bit wr, sync;
      int word, ch;
      bit nen[N];
      wr   = device_req_i && device_we_i;
      word = int'(device_addr_i[11:2]);
      nen  = m_en;
      sync = wr && word == 'h201 && device_be_i != 4'h0 && device_wdata_i[0];
      if (wr && word == 'h200)
        for (int i = 0; i < N && i < 32; i++) if (device_be_i[i/8]) nen[i] = device_wdata_i[i];
      for (int i = 0; i < N; i++) begin
        m_pwm[i] = m_en[i] && (m_phase[i] < m_dact[i]);
        if (!(m_en[i] && nen[i]) || sync || m_phase[i] == m_pact[i]) begin
          m_phase[i] = 0; m_dact[i] = m_duty[i]; m_pact[i] = m_per[i];
        end else begin
          m_phase[i]++;
        end
      end
      if (wr && word < 'h200) begin
        ch = word / 2;
        if (ch < N) begin
          if (word % 2 == 1) m_per[ch] = merge(m_per[ch], device_wdata_i, device_be_i, W);
          else m_duty[ch] = merge(m_duty[ch], device_wdata_i, device_be_i, W);
        end
      end
      m_en = nen;
    end
  end

  // Monitor: response timing, scoreboard pop, and per-cycle output check.
  always @(posedge clk_i) begin
    logic req_seen;
    rsp_t e;
    req_seen = device_req_i && rst_ni;
    #1;
    check("rvalid", 64'(device_rvalid_o), 64'(req_seen));
    if (device_rvalid_o) begin
      if (exp_q.size() == 0) check("orphan_rsp", 64'(1), 64'(0));
      else begin
        e = exp_q.pop_front();
        check("err", 64'(device_err_o), 64'(e.err));
        if (e.chk_data) check("rdata", 64'(device_rdata_o), 64'(e.rdata));
      end
    end
    check("pwm", 64'(pwm_o), 64'(m_pwm));
  end

  task automatic bus(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    @(negedge clk_i);
    device_req_i = 1'b1; device_we_i = we; device_addr_i = addr;
    device_be_i = be; device_wdata_i = wd;
    exp_q.push_back(exp_rsp(we, addr));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      device_req_i = 1'b0; device_we_i = 1'b0;
    end
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk_i);
      device_req_i = 1'b0;
      @(posedge clk_i);
      #1;
      if (pwm_o[ch]) hi++;
    end
  endtask

  initial begin
    int hi, mism, sel, ch;
    logic [31:0] r, a, wd;
    logic [9:0]  w;
    logic [3:0]  be;

    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    idle(2);

    // Reset readback
    bus(1'b0, 32'h000, 4'hF, '0);
    bus(1'b0, 32'h004, 4'hF, '0);
    bus(1'b0, 32'h800, 4'hF, '0);
    idle(2);
    check("reset_pwm", 64'(pwm_o), 64'(0));

    // Basic waveform: PERIOD=9, DUTY=3, first high two cycles after enable
    bus(1'b1, 32'h004, 4'hF, 32'd9);
    bus(1'b1, 32'h000, 4'hF, 32'd3);
    bus(1'b1, 32'h800, 4'hF, 32'd1);
    @(posedge clk_i); #1;
    check("enable_t1_low", 64'(pwm_o[0]), 64'(0));
    idle(1);
    @(posedge clk_i); #1;
    check("enable_t2_high", 64'(pwm_o[0]), 64'(1));
    idle(12);
    count_high(0, 30, hi); check("duty3_of_10", 64'(hi), 64'(9));

    // Mid-period duty change
    idle(4);
    bus(1'b1, 32'h000, 4'hF, 32'd7);
    idle(25);
    count_high(0, 30, hi); check("duty7_of_10", 64'(hi), 64'(21));

    // Boundary cases
    bus(1'b1, 32'h000, 4'hF, 32'd0);
    idle(25);
    count_high(0, 30, hi); check("duty0_low", 64'(hi), 64'(0));
    bus(1'b1, 32'h000, 4'hF, 32'd12);
    idle(25);
    count_high(0, 30, hi); check("duty_gt_per_high", 64'(hi), 64'(30));
    bus(1'b1, 32'h000, 4'hF, 32'd1);
    bus(1'b1, 32'h004, 4'hF, 32'd0);
    idle(25);
    count_high(0, 30, hi); check("per0_high", 64'(hi), 64'(30));
    bus(1'b1, 32'h000, 4'hF, 32'd128);
    bus(1'b1, 32'h004, 4'hF, 32'd255);
    idle(10);
    count_high(0, 512, hi); check("half_duty_256", 64'(hi), 64'(256));

    // Byte enables
    bus(1'b1, 32'h000, 4'hF, 32'd0);
    bus(1'b1, 32'h000, 4'b0010, 32'hFFFF_FFFF);
    bus(1'b0, 32'h000, 4'hF, '0);
    bus(1'b1, 32'h000, 4'b0001, 32'hFFFF_FFFF);
    bus(1'b0, 32'h000, 4'hF, '0);
    idle(2);

    // Unmapped offsets
    bus(1'b1, 32'h808, 4'hF, 32'hFFFF_FFFF);
    bus(1'b0, 32'h808, 4'hF, '0);
    bus(1'b0, 32'(8 * N), 4'hF, '0);
    bus(1'b1, 32'(8 * N + 4), 4'hF, 32'd5);
    bus(1'b0, 32'h000, 4'hF, '0);
    bus(1'b0, 32'h004, 4'hF, '0);
    bus(1'b0, 32'h800, 4'hF, '0);
    bus(1'b0, 32'h804, 4'hF, '0);
    idle(2);

    // SYNC aligns two channels running at different phases
    bus(1'b1, 32'h800, 4'hF, 32'd0);
    bus(1'b1, 32'h004, 4'hF, 32'd9);
    bus(1'b1, 32'h000, 4'hF, 32'd3);
    bus(1'b1, 32'h00C, 4'hF, 32'd9);
    bus(1'b1, 32'h008, 4'hF, 32'd3);
    bus(1'b1, 32'h800, 4'hF, 32'd1);
    idle(3);
    bus(1'b1, 32'h800, 4'hF, 32'd3);
    idle(4);
    bus(1'b1, 32'h804, 4'h1, 32'd1);
    idle(1);
    mism = 0;
    repeat (20) begin
      @(posedge clk_i); #1;
      if (pwm_o[0] !== pwm_o[1]) mism++;
    end
    check("sync_aligned", 64'(mism), 64'(0));

    // Randomised traffic against the model
    for (int it = 0; it < 400; it++) begin
      r   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel <= 4) begin
        ch = $urandom_range(0, N);
        w  = 10'(ch * 2 + $urandom_range(0, 1));
      end else if (sel <= 6) w = 10'h200;
      else if (sel == 7)     w = 10'h201;
      else                   w = 10'($urandom_range(32'h202, 32'h3FF));
      a  = {r[31:12], w, r[1:0]};
      wd = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 20));
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      bus(1'($urandom_range(0, 1)), a, be, wd);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(3);

    // Asynchronous reset mid-period
    bus(1'b1, 32'h004, 4'hF, 32'd9);
    bus(1'b1, 32'h000, 4'hF, 32'd5);
    bus(1'b1, 32'h800, 4'hF, 32'd1);
    idle(7);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_pwm", 64'(pwm_o), 64'(0));
    check("async_rst_rvalid", 64'(device_rvalid_o), 64'(0));
    idle(2);
    rst_ni = 1'b1;
    idle(2);
    bus(1'b0, 32'h800, 4'hF, '0);
    bus(1'b0, 32'h000, 4'hF, '0);
    idle(3);
    count_high(0, 30, hi); check("post_rst_disabled", 64'(hi), 64'(0));

    idle(3);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
